// File: rtl/sm_mac_requant_pkg.sv
// Shared constants for the streaming MAC with requantised output:
// FSM state encodings and the width of the shift configuration field.
package sm_mac_requant_pkg;

  localparam int c_shift_nbits = 6;

  typedef logic [c_shift_nbits-1:0] shift_t;

  localparam logic [1:0] st_acc   = 2'd0;
  localparam logic [1:0] st_drain = 2'd1;
  localparam logic [1:0] st_done  = 2'd2;

endpackage

// File: rtl/sm_requant.sv
// Combinational requantiser: arithmetic right shift, signed saturation to
// p_nbits, optional ReLU. Reusable wherever a wide sum must be narrowed.
module sm_requant
  import sm_mac_requant_pkg::*;
#(
  parameter int p_acc_nbits = 40,
  parameter int p_nbits     = 16,
  parameter int p_relu      = 1
) (
  input  logic signed [p_acc_nbits-1:0] sum,
  input  shift_t                        shift,
  output logic        [p_nbits-1:0]     data,
  output logic                          ovf
);

  localparam logic signed [p_acc_nbits-1:0] sat_max =
    {{(p_acc_nbits-p_nbits+1){1'b0}}, {(p_nbits-1){1'b1}}};
  localparam logic signed [p_acc_nbits-1:0] sat_min =
    {{(p_acc_nbits-p_nbits+1){1'b1}}, {(p_nbits-1){1'b0}}};

  logic signed [p_acc_nbits-1:0] shifted;
  logic        [p_nbits-1:0]     clamped;

  assign shifted = sum >>> shift;

  // NOTE: every output gets a default at the top of always_comb so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    ovf     = 1'b0;
    clamped = shifted[p_nbits-1:0];
    if (shifted > sat_max) begin
      clamped = sat_max[p_nbits-1:0];
      ovf     = 1'b1;
    end else if (shifted < sat_min) begin
      clamped = sat_min[p_nbits-1:0];
      ovf     = 1'b1;
    end
    data = clamped;
    // ReLU zeroes the value but keeps the saturation flag visible.
    if ((p_relu != 0) && clamped[p_nbits-1]) begin
      data = '0;
    end
  end

endmodule

// File: rtl/sm_mac_requant.sv
// Streaming signed multiply-accumulate: one beat per cycle into a wide
// wrapping accumulator, then a requantised result with a valid/ready handshake.
module sm_mac_requant
  import sm_mac_requant_pkg::*;
#(
  parameter int p_nbits     = 16,
  parameter int p_acc_nbits = 40,
  parameter int p_relu      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic signed [p_nbits-1:0] in_a,
  input  logic signed [p_nbits-1:0] in_b,
  input  logic                      in_last,
  input  shift_t                    cfg_shift,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic        [p_nbits-1:0] out_data,
  output logic                      out_ovf
);

  localparam int p_prod_nbits = 2 * p_nbits;

  logic [1:0] state_q, state_d;

  logic signed [p_prod_nbits-1:0] prod_q;
  logic                           prod_val_q;
  logic signed [p_acc_nbits-1:0]  acc_q;
  logic signed [p_acc_nbits-1:0]  prod_ext;
  logic signed [p_acc_nbits-1:0]  sum;
  shift_t                         shift_q;
  logic                           first_q;

  logic                           in_hs;
  logic                           out_hs;
  logic        [p_nbits-1:0]      rq_data;
  logic                           rq_ovf;

  assign in_rdy  = (state_q == st_acc);
  assign out_val = (state_q == st_done);
  assign in_hs   = in_val & in_rdy;
  assign out_hs  = out_val & out_rdy;

  // In DRAIN the last product is still in flight, so the final sum is
  // formed here and consumed both by the accumulator and the requantiser.
  assign prod_ext = prod_val_q ? p_acc_nbits'(prod_q) : '0;
  assign sum      = acc_q + prod_ext;

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_acc:   if (in_hs && in_last) state_d = st_drain;
      st_drain: state_d = st_done;
      st_done:  if (out_hs) state_d = st_acc;
      default:  state_d = st_acc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= st_acc;
      prod_q     <= '0;
      prod_val_q <= 1'b0;
      acc_q      <= '0;
      shift_q    <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      prod_val_q <= in_hs;
      if (in_hs) begin
        prod_q <= p_prod_nbits'(in_a) * p_prod_nbits'(in_b);
      end

      if (out_hs) begin
        acc_q <= '0;
      end else if (prod_val_q) begin
        acc_q <= sum;
      end

      if (out_hs) begin
        first_q <= 1'b1;
      end else if (in_hs) begin
        first_q <= 1'b0;
      end

      if (in_hs && first_q) begin
        shift_q <= cfg_shift;
      end
    end
  end

  sm_requant #(
    .p_acc_nbits (p_acc_nbits),
    .p_nbits     (p_nbits),
    .p_relu      (p_relu)
  ) u_requant (
    .sum   (sum),
    .shift (shift_q),
    .data  (rq_data),
    .ovf   (rq_ovf)
  );

  // Result registers load only on DRAIN->DONE, so they hold under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (state_q == st_drain) begin
      out_data <= rq_data;
      out_ovf  <= rq_ovf;
    end
  end

endmodule

// File: tb/tb_sm_mac_requant.sv
// Directed bench: a ReLU instance and a linear instance share one stimulus
// stream; expected values are hand-computed constants.
module tb_sm_mac_requant;
  import sm_mac_requant_pkg::*;

  logic               clk;
  logic               reset;
  logic               in_val;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               in_last;
  shift_t             cfg_shift;
  logic               out_rdy;

  logic        in_rdy_r, out_val_r, out_ovf_r;
  logic [15:0] out_data_r;
  logic        in_rdy_l, out_val_l, out_ovf_l;
  logic [15:0] out_data_l;

  int n_checks = 0;
  int n_fail   = 0;

  sm_mac_requant #(.p_nbits(16), .p_acc_nbits(40), .p_relu(1)) dut_relu (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy_r),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .cfg_shift (cfg_shift),
    .out_val   (out_val_r),
    .out_rdy   (out_rdy),
    .out_data  (out_data_r),
    .out_ovf   (out_ovf_r)
  );

  sm_mac_requant #(.p_nbits(16), .p_acc_nbits(40), .p_relu(0)) dut_lin (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy_l),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .cfg_shift (cfg_shift),
    .out_val   (out_val_l),
    .out_rdy   (out_rdy),
    .out_data  (out_data_l),
    .out_ovf   (out_ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic last, input shift_t sh);
    in_val    = 1'b1;
    in_a      = a;
    in_b      = b;
    in_last   = last;
    cfg_shift = sh;
    check("beat_in_rdy", 32'(in_rdy_r), 32'd1);
    tick();
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  // Bounded wait for out_val; an expired bound shows up as a failed check.
  task automatic wait_out(input string tag);
    for (int k = 0; k < 8; k++) begin
      if (out_val_r) break;
      tick();
    end
    check(tag, 32'(out_val_r), 32'd1);
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("consume_out_val", 32'(out_val_r), 32'd0);
    check("consume_in_rdy", 32'(in_rdy_r), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_val    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    cfg_shift = '0;
    out_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_rdy",   32'(in_rdy_r),   32'd1);
    check("rst_out_val",  32'(out_val_r),  32'd0);
    check("rst_out_data", 32'(out_data_r), 32'd0);
    check("rst_out_ovf",  32'(out_ovf_r),  32'd0);
    reset = 1'b0;
    tick();

    // Single-beat latency: accepted in cycle t, out_val in t+2
    beat(16'sd3, 16'sd4, 1'b1, 6'd0);
    check("lat_t1_out_val", 32'(out_val_r), 32'd0);
    check("lat_t1_in_rdy",  32'(in_rdy_r),  32'd0);
    tick();
    check("lat_t2_out_val", 32'(out_val_r),  32'd1);
    check("lat_data",       32'(out_data_r), 32'd12);
    check("lat_ovf",        32'(out_ovf_r),  32'd0);
    consume();

    // Streaming without bubbles; shift latched on beat 0 only.
    // out_rdy held high throughout: ignored until DONE.
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val    = 1'b1;
      in_a      = 16'(i + 1);
      in_b      = 16'sd10;
      in_last   = (i == 3);
      cfg_shift = (i == 0) ? 6'd1 : 6'd5;
      check("stream_in_rdy", 32'(in_rdy_r), 32'd1);
      tick();
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    check("stream_drain_out_val", 32'(out_val_r), 32'd0);
    tick();
    check("stream_out_val", 32'(out_val_r),  32'd1);
    check("stream_data",    32'(out_data_r), 32'd50);
    check("stream_ovf",     32'(out_ovf_r),  32'd0);
    tick();
    out_rdy = 1'b0;
    check("stream_consumed", 32'(out_val_r), 32'd0);

    // ReLU vs linear: -5*7 = -35
    beat(-16'sd5, 16'sd7, 1'b1, 6'd0);
    wait_out("relu_wait");
    check("relu_data_r", 32'(out_data_r), 32'h0000);
    check("relu_ovf_r",  32'(out_ovf_r),  32'd0);
    check("relu_data_l", 32'(out_data_l), 32'h0000FFDD);
    check("relu_ovf_l",  32'(out_ovf_l),  32'd0);
    consume();

    // Positive saturation: 2 * 32767^2
    beat(16'sd32767, 16'sd32767, 1'b0, 6'd0);
    beat(16'sd32767, 16'sd32767, 1'b1, 6'd0);
    wait_out("satp_wait");
    check("satp_data_r", 32'(out_data_r), 32'h7FFF);
    check("satp_ovf_r",  32'(out_ovf_r),  32'd1);
    check("satp_data_l", 32'(out_data_l), 32'h7FFF);
    check("satp_ovf_l",  32'(out_ovf_l),  32'd1);
    consume();

    // Negative saturation: ReLU output 0 but overflow still flagged
    beat(16'sd32767, -16'sd32767, 1'b0, 6'd0);
    beat(16'sd32767, -16'sd32767, 1'b1, 6'd0);
    wait_out("satn_wait");
    check("satn_data_r", 32'(out_data_r), 32'h0000);
    check("satn_ovf_r",  32'(out_ovf_r),  32'd1);
    check("satn_data_l", 32'(out_data_l), 32'h8000);
    check("satn_ovf_l",  32'(out_ovf_l),  32'd1);
    consume();

    // Backpressure: 6*7 = 42 >>> 1 = 21, held for 5 cycles while
    // in_val is driven (and must be ignored).
    beat(16'sd6, 16'sd7, 1'b1, 6'd1);
    wait_out("bp_wait");
    for (int i = 0; i < 5; i++) begin
      in_val  = 1'b1;
      in_a    = 16'sd9;
      in_b    = 16'sd9;
      in_last = 1'b1;
      check("bp_out_val",  32'(out_val_r),  32'd1);
      check("bp_out_data", 32'(out_data_r), 32'd21);
      check("bp_out_ovf",  32'(out_ovf_r),  32'd0);
      check("bp_in_rdy",   32'(in_rdy_r),   32'd0);
      tick();
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    check("bp_final_data", 32'(out_data_r), 32'd21);
    consume();

    // Accumulator cleared after handshake
    beat(16'sd2, 16'sd2, 1'b1, 6'd0);
    wait_out("clr_wait");
    check("clr_data", 32'(out_data_r), 32'd4);
    consume();

    // Reset mid-vector discards partial sum
    beat(16'sd100, 16'sd100, 1'b0, 6'd0);
    beat(16'sd100, 16'sd100, 1'b0, 6'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_in_rdy",  32'(in_rdy_r),  32'd1);
    check("mid_rst_out_val", 32'(out_val_r), 32'd0);
    tick();
    reset = 1'b0;
    check("post_rst_in_rdy", 32'(in_rdy_r), 32'd1);
    beat(16'sd1, 16'sd1, 1'b1, 6'd0);
    wait_out("post_rst_wait");
    check("post_rst_data", 32'(out_data_r), 32'd1);
    check("post_rst_ovf",  32'(out_ovf_r),  32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_mac_requant.md
SM_MAC_REQUANT -- requirements
Module: sm_mac_requant

Interface
REQ-001 Parameter p_nbits, default 16: signed operand and result width.
REQ-002 Parameter p_acc_nbits, default 40: signed accumulator width; SHALL be >= 2*p_nbits.
REQ-003 Parameter p_relu, default 1: 1 = apply ReLU to the result, 0 = pass signed result.
REQ-004 Port clk  input  1: single clock; all state SHALL update on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port in_val  input  1: operand beat valid.
REQ-007 Port in_rdy  output  1: operand beat accepted when in_val & in_rdy.
REQ-008 Port in_a  input  p_nbits: signed operand A.
REQ-009 Port in_b  input  p_nbits: signed operand B.
REQ-010 Port in_last  input  1: beat is the final element of the vector.
REQ-011 Port cfg_shift  input  6: arithmetic right-shift amount; sampled only on the first beat of each vector.
REQ-012 Port out_val  output  1: result valid.
REQ-013 Port out_rdy  input  1: result consumed when out_val & out_rdy.
REQ-014 Port out_data  output  p_nbits: requantised result.
REQ-015 Port out_ovf  output  1: saturation occurred for this result.

Function
REQ-016 FSM states: ACC, DRAIN and DONE; in_rdy SHALL be 1 only in ACC; out_val SHALL be 1 only in DONE.
REQ-017 Stage 1: an accepted beat SHALL register prod = in_a*in_b (full 2*p_nbits signed) plus a prod_val flag at the same edge.
REQ-018 Stage 2: when prod_val=1, acc SHALL become acc + sign-extended prod at the next edge; acc wraps modulo 2^p_acc_nbits and never saturates.
REQ-019 Throughput: one beat per cycle while in ACC, with no bubbles required.
REQ-020 ACC->DRAIN on an accepted beat with in_last=1; DRAIN->DONE unconditionally after one cycle; DONE->ACC on out_val & out_rdy.
REQ-021 On the DRAIN->DONE edge, the final sum (acc + last prod) SHALL be requantised and registered into out_data/out_ovf.
REQ-022 Latency: for a last beat accepted in cycle t, out_val SHALL be 1 in cycle t+2.
REQ-023 Requantisation sequence:
- s = sum >>> shift, where shift is the latched cfg_shift.
- If s > 2^(p_nbits-1)-1 or s < -2^(p_nbits-1), clamp to that bound and set out_ovf=1; otherwise out_ovf=0.
- If p_relu=1 and the clamped value is negative, out_data SHALL be 0; out_ovf SHALL still reflect the saturation.
REQ-024 cfg_shift SHALL be latched on the first accepted beat of a vector (beat counter = 0); a single-beat vector uses the cfg_shift presented with that beat.
REQ-025 out_data and out_ovf SHALL be held stable while out_val=1 and out_rdy=0.
REQ-026 On the DONE->ACC handshake, acc and the first-beat flag SHALL clear, so the next vector starts from 0.
REQ-027 in_val is ignored outside ACC.
REQ-028 out_rdy is ignored outside DONE.

Reset
REQ-029 Reset SHALL asynchronously force the following values:
- state=ACC
- acc=0
- prod=0
- prod_val=0
- shift latch=0
- first-beat flag=1
- out_val=0
- out_data=0
- out_ovf=0
REQ-030 Assertion mid-vector SHALL discard all partial accumulation; in_rdy=1 in the first cycle after deassertion.

Structure
REQ-031 State encodings and the cfg_shift width constant SHALL live in shared package sm_mac_requant_pkg.
REQ-032 The shift/saturate/ReLU datapath SHALL be a separate combinational sub-module sm_requant (parameters p_acc_nbits, p_nbits, p_relu), reusable elsewhere.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Single-beat latency: a=3, b=4, last=1, shift=0 accepted in cycle t -> out_val in t+2, out_data=12, out_ovf=0.
- Streaming, no bubbles: a=1,2,3,4 with b=10 each, shift=1 on beat 0 (then changed to 5) -> out_data=50.
- ReLU mode: a=-5, b=7, last=1 -> out_data=0 when p_relu=1; out_data=0xFFDD when p_relu=0; out_ovf=0 in both.
- Saturation: two beats of a=32767, b=32767, shift=0 -> out_data=32767, out_ovf=1. Same with b=-32767 and p_relu=1 -> out_data=0, out_ovf=1.
- Backpressure: out_rdy=0 for 5 cycles -> out_val, out_data and out_ovf stable, in_rdy=0 throughout. A following 1-beat vector a=2, b=2 -> out_data=4 (acc cleared).
- Reset mid-vector: reset after beats a=100, b=100 ×2, then vector a=1, b=1, last=1 -> out_data=1.
